// File: rtl/dsp_decode_pkg.sv
// Shared widths, instruction field layout, opcodes and the decoded-word payload
// for the DSP decode stage.
package dsp_decode_pkg;

    localparam int unsigned INST_W     = 32;
    localparam int unsigned MEM_ADDR_W = 16;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned IMM_W      = 16;
    localparam int unsigned FLUSH_W    = 2;

    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RD_LSB     = 21;
    localparam int unsigned RS_LSB     = 16;
    localparam int unsigned RT_LSB     = 11;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 6'h00,
        OP_ADD  = 6'h01,
        OP_SUB  = 6'h02,
        OP_MUL  = 6'h03,
        OP_MAC  = 6'h04,
        OP_LD   = 6'h08,
        OP_ST   = 6'h09,
        OP_LDI  = 6'h0A,
        OP_JMP  = 6'h10,
        OP_HALT = 6'h3F
    } opcode_e;

    // Contents of the decode output register handed to execute.
    typedef struct packed {
        logic                  valid;
        logic [OPCODE_W-1:0]   opcode;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [INST_W-1:0]     imm;
        logic [MEM_ADDR_W-1:0] pc;
        logic                  we_reg;
        logic                  is_load;
        logic                  is_store;
    } dec_word_t;

endpackage

// File: rtl/dsp_decode_field_decode.sv
// Purely combinational split of one instruction word into fields and control flags.
// Undefined opcodes come out as NOP with the illegal flag raised.
module dsp_field_decode
    import dsp_decode_pkg::*;
(
    input  logic [INST_W-1:0]     instr_i,
    output logic [OPCODE_W-1:0]   opcode_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [REG_ADDR_W-1:0] rs_o,
    output logic [REG_ADDR_W-1:0] rt_o,
    output logic [INST_W-1:0]     imm_o,
    output logic                  we_reg_o,
    output logic                  is_load_o,
    output logic                  is_store_o,
    output logic                  is_jmp_o,
    output logic                  is_halt_o,
    output logic                  illegal_o
);

    logic [OPCODE_W-1:0] raw_op;

    always_comb begin
        raw_op     = instr_i[OPCODE_LSB +: OPCODE_W];
        rd_o       = instr_i[RD_LSB +: REG_ADDR_W];
        rs_o       = instr_i[RS_LSB +: REG_ADDR_W];
        rt_o       = instr_i[RT_LSB +: REG_ADDR_W];
        imm_o      = {{(INST_W - IMM_W){instr_i[IMM_W-1]}}, instr_i[IMM_W-1:0]};
        opcode_o   = raw_op;
        we_reg_o   = 1'b0;
        is_load_o  = 1'b0;
        is_store_o = 1'b0;
        is_jmp_o   = 1'b0;
        is_halt_o  = 1'b0;
        illegal_o  = 1'b0;
        case (opcode_e'(raw_op))
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_LDI: we_reg_o = 1'b1;
            OP_LD: begin
                we_reg_o  = 1'b1;
                is_load_o = 1'b1;
            end
            OP_ST:   is_store_o = 1'b1;
            OP_JMP:  is_jmp_o   = 1'b1;
            OP_HALT: is_halt_o  = 1'b1;
            default: begin
                opcode_o  = OP_NOP;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dsp_decode.sv
// Decode stage behind DSPFetch: registers decoded fields for execute, resolves jumps,
// drops wrong-path words, inserts load-use bubbles and back-pressures fetch.
module dsp_decode
    import dsp_decode_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INST_W-1:0]     instr_i,
    input  logic                  instr_valid_i,
    input  logic [MEM_ADDR_W-1:0] pc_i,
    output logic                  fetch_stall_o,
    output logic                  jump_flag_o,
    output logic [MEM_ADDR_W-1:0] jump_addr_o,
    input  logic                  ex_ready_i,
    output logic                  dec_valid_o,
    output logic [OPCODE_W-1:0]   dec_opcode_o,
    output logic [REG_ADDR_W-1:0] dec_rd_o,
    output logic [REG_ADDR_W-1:0] dec_rs_o,
    output logic [REG_ADDR_W-1:0] dec_rt_o,
    output logic [INST_W-1:0]     dec_imm_o,
    output logic [MEM_ADDR_W-1:0] dec_pc_o,
    output logic                  dec_we_reg_o,
    output logic                  dec_is_load_o,
    output logic                  dec_is_store_o,
    output logic                  illegal_op_o,
    output logic                  halted_o
);

    logic [OPCODE_W-1:0]   f_opcode;
    logic [REG_ADDR_W-1:0] f_rd;
    logic [REG_ADDR_W-1:0] f_rs;
    logic [REG_ADDR_W-1:0] f_rt;
    logic [INST_W-1:0]     f_imm;
    logic                  f_we_reg;
    logic                  f_is_load;
    logic                  f_is_store;
    logic                  f_is_jmp;
    logic                  f_is_halt;
    logic                  f_illegal;

    dsp_field_decode u_field_decode (
        .instr_i    (instr_i),
        .opcode_o   (f_opcode),
        .rd_o       (f_rd),
        .rs_o       (f_rs),
        .rt_o       (f_rt),
        .imm_o      (f_imm),
        .we_reg_o   (f_we_reg),
        .is_load_o  (f_is_load),
        .is_store_o (f_is_store),
        .is_jmp_o   (f_is_jmp),
        .is_halt_o  (f_is_halt),
        .illegal_o  (f_illegal)
    );

    dec_word_t             dec_q, dec_d;
    logic [FLUSH_W-1:0]    flush_q, flush_d;
    logic                  jump_flag_q, jump_flag_d;
    logic [MEM_ADDR_W-1:0] jump_addr_q, jump_addr_d;
    logic                  illegal_q, illegal_d;
    logic                  halted_q, halted_d;

    logic flushing;
    logic hazard;
    logic take;
    logic accept;
    logic drop;
    logic load_en;

    // Handshake: a word in the wrong-path window is dropped and never causes a hazard.
    always_comb begin
        flushing      = (flush_q != '0);
        hazard        = instr_valid_i && !flushing && dec_q.valid && dec_q.is_load
                        && (dec_q.rd != '0) && ((f_rs == dec_q.rd) || (f_rt == dec_q.rd));
        fetch_stall_o = (dec_q.valid && !ex_ready_i) || hazard || halted_q;
        take          = instr_valid_i && !fetch_stall_o;
        accept        = take && !flushing;
        drop          = take && flushing;
        load_en       = !dec_q.valid || ex_ready_i;
    end

    // Next-state for output register, flush window, jump pulse and halt flag.
    always_comb begin
        dec_d       = dec_q;
        flush_d     = flush_q;
        jump_flag_d = 1'b0;
        jump_addr_d = '0;
        illegal_d   = 1'b0;
        halted_d    = halted_q;

        if (load_en) begin
            dec_d = '0;
            if (accept) begin
                dec_d.valid    = 1'b1;
                dec_d.opcode   = f_opcode;
                dec_d.rd       = f_rd;
                dec_d.rs       = f_rs;
                dec_d.rt       = f_rt;
                dec_d.imm      = f_imm;
                dec_d.pc       = pc_i;
                dec_d.we_reg   = f_we_reg;
                dec_d.is_load  = f_is_load;
                dec_d.is_store = f_is_store;
            end
        end

        if (accept && f_is_jmp) begin
            jump_flag_d = 1'b1;
            jump_addr_d = f_imm[MEM_ADDR_W-1:0];
        end

        if (drop) begin
            flush_d = flush_q - FLUSH_W'(1);
        end else if (accept && f_is_jmp) begin
            flush_d = FLUSH_W'(FLUSH_CYCLES);
        end

        illegal_d = accept && f_illegal;

        if (accept && f_is_halt) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dec_q       <= '0;
            flush_q     <= '0;
            jump_flag_q <= 1'b0;
            jump_addr_q <= '0;
            illegal_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            dec_q       <= dec_d;
            flush_q     <= flush_d;
            jump_flag_q <= jump_flag_d;
            jump_addr_q <= jump_addr_d;
            illegal_q   <= illegal_d;
            halted_q    <= halted_d;
        end
    end

    assign jump_flag_o    = jump_flag_q;
    assign jump_addr_o    = jump_addr_q;
    assign dec_valid_o    = dec_q.valid;
    assign dec_opcode_o   = dec_q.opcode;
    assign dec_rd_o       = dec_q.rd;
    assign dec_rs_o       = dec_q.rs;
    assign dec_rt_o       = dec_q.rt;
    assign dec_imm_o      = dec_q.imm;
    assign dec_pc_o       = dec_q.pc;
    assign dec_we_reg_o   = dec_q.we_reg;
    assign dec_is_load_o  = dec_q.is_load;
    assign dec_is_store_o = dec_q.is_store;
    assign illegal_op_o   = illegal_q;
    assign halted_o       = halted_q;

endmodule

// File: tb/tb_dsp_decode.sv
// Self-checking bench for dsp_decode: directed scenarios plus a random instruction
// stream, all checked against a cycle-level reference model of the decode rules.
module tb_dsp_decode;
    import dsp_decode_pkg::*;

    localparam int unsigned FLUSH = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic        ex_ready;
    logic        fetch_stall;
    logic        jump_flag;
    logic [15:0] jump_addr;
    logic        dec_valid;
    logic [5:0]  dec_opcode;
    logic [4:0]  dec_rd, dec_rs, dec_rt;
    logic [31:0] dec_imm;
    logic [15:0] dec_pc;
    logic        dec_we_reg, dec_is_load, dec_is_store;
    logic        illegal_op;
    logic        halted;

    always #5 clk = ~clk;

    dsp_decode #(.FLUSH_CYCLES(FLUSH)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_i        (instr),
        .instr_valid_i  (instr_valid),
        .pc_i           (pc),
        .fetch_stall_o  (fetch_stall),
        .jump_flag_o    (jump_flag),
        .jump_addr_o    (jump_addr),
        .ex_ready_i     (ex_ready),
        .dec_valid_o    (dec_valid),
        .dec_opcode_o   (dec_opcode),
        .dec_rd_o       (dec_rd),
        .dec_rs_o       (dec_rs),
        .dec_rt_o       (dec_rt),
        .dec_imm_o      (dec_imm),
        .dec_pc_o       (dec_pc),
        .dec_we_reg_o   (dec_we_reg),
        .dec_is_load_o  (dec_is_load),
        .dec_is_store_o (dec_is_store),
        .illegal_op_o   (illegal_op),
        .halted_o       (halted)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: what execute should see, plus pending side effects.
    bit          m_valid;
    logic [31:0] m_word;
    logic [15:0] m_pc;
    int          m_flush;
    bit          m_halted;
    bit          m_jump;
    logic [15:0] m_jaddr;
    bit          m_ill;

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h10, 6'h3F};
    endfunction

    function automatic bit writes_rd(input logic [5:0] op);
        return op inside {6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0A};
    endfunction

    function automatic logic [31:0] enc(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rd), 5'(rs), 5'(rt), 11'd0};
    endfunction

    function automatic logic [31:0] enc_imm(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'd0, imm};
    endfunction

    function automatic bit ref_stall(input bit iv, input logic [31:0] w, input bit ex);
        logic [4:0] lrd;
        bit         haz;
        lrd = m_word[25:21];
        haz = iv && (m_flush == 0) && m_valid && (m_word[31:26] == 6'h08) && (lrd != 5'd0)
              && ((w[20:16] == lrd) || (w[15:11] == lrd));
        return (m_valid && !ex) || haz || m_halted;
    endfunction

    task automatic model_update(input bit r, input bit iv, input logic [31:0] w,
                                input logic [15:0] p, input bit ex, input bit stall);
        bit take, acc, drop;
        if (r) begin
            m_valid = 0; m_word = '0; m_pc = '0; m_flush = 0;
            m_halted = 0; m_jump = 0; m_jaddr = '0; m_ill = 0;
            return;
        end
        take = iv && !stall;
        acc  = take && (m_flush == 0);
        drop = take && (m_flush > 0);
        if (!m_valid || ex) begin
            m_valid = acc;
            if (acc) begin
                m_word = w;
                m_pc   = p;
            end
        end
        m_jump = acc && (w[31:26] == 6'h10);
        if (m_jump) m_jaddr = w[15:0];
        m_ill = acc && !legal(w[31:26]);
        if (drop) m_flush = m_flush - 1;
        else if (m_jump) m_flush = FLUSH;
        if (acc && (w[31:26] == 6'h3F)) m_halted = 1;
    endtask

    task automatic check_outputs();
        logic [5:0]  op;
        logic [31:0] exp_imm;
        op      = m_word[31:26];
        exp_imm = 32'($signed(m_word[15:0]));
        chk("dec_valid", 64'(dec_valid), 64'(m_valid));
        if (m_valid) begin
            chk("dec_opcode", 64'(dec_opcode), 64'(legal(op) ? op : 6'h00));
            chk("dec_regs", 64'({dec_rd, dec_rs, dec_rt}),
                64'({m_word[25:21], m_word[20:16], m_word[15:11]}));
            chk("dec_imm", 64'(dec_imm), 64'(exp_imm));
            chk("dec_pc", 64'(dec_pc), 64'(m_pc));
            chk("dec_flags", 64'({dec_we_reg, dec_is_load, dec_is_store}),
                64'({writes_rd(op), op == 6'h08, op == 6'h09}));
        end
        chk("jump_flag", 64'(jump_flag), 64'(m_jump));
        if (m_jump) chk("jump_addr", 64'(jump_addr), 64'(m_jaddr));
        chk("illegal_op", 64'(illegal_op), 64'(m_ill));
        chk("halted", 64'(halted), 64'(m_halted));
    endtask

    // One clock: drive at negedge, check stall before the edge, check registers after it.
    task automatic step(input bit r, input bit iv, input logic [31:0] w, input logic [15:0] p,
                        input bit ex, output bit stall_seen);
        bit exp_stall;
        @(negedge clk);
        rst = r; instr_valid = iv; instr = w; pc = p; ex_ready = ex;
        #1;
        exp_stall  = ref_stall(iv, w, ex);
        stall_seen = fetch_stall;
        if (!r) chk("fetch_stall", 64'(fetch_stall), 64'(exp_stall));
        model_update(r, iv, w, p, ex, exp_stall);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        int         k;
        k = int'($urandom_range(31));
        if (k < 2) begin
            op = 6'($urandom);
            while (legal(op)) op = 6'($urandom);
        end else if (k == 2) op = 6'h3F;
        else if (k < 6) op = 6'h10;
        else if (k < 14) op = 6'h08;
        else begin
            case ($urandom_range(6))
                0: op = 6'h00;
                1: op = 6'h01;
                2: op = 6'h02;
                3: op = 6'h03;
                4: op = 6'h04;
                5: op = 6'h09;
                default: op = 6'h0A;
            endcase
        end
        return {op, 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)), 11'($urandom)};
    endfunction

    initial begin
        bit          s;
        bit          last_stall;
        bit          cur_iv;
        logic [31:0] cur_w;
        logic [15:0] cur_p;
        bit          r;
        bit          ex;

        rst = 1'b1; instr_valid = 1'b0; instr = '0; pc = '0; ex_ready = 1'b1;

        // Reset, then idle.
        step(1, 0, '0, '0, 1, s);
        step(1, 0, '0, '0, 1, s);
        chk("rst_outputs", 64'({fetch_stall, jump_flag, jump_addr, dec_valid, dec_opcode, dec_rd,
                                dec_rs, dec_rt, dec_we_reg, dec_is_load, dec_is_store,
                                illegal_op, halted}), 64'd0);
        chk("rst_imm_pc", 64'({dec_imm, dec_pc}), 64'd0);
        step(0, 0, '0, '0, 1, s);
        chk("idle_valid", 64'(dec_valid), 64'd0);

        // ADD r3,r1,r2 at pc 4.
        step(0, 1, enc(6'h01, 3, 1, 2), 16'd4, 1, s);
        chk("add_fields", 64'({dec_valid, dec_opcode, dec_rd, dec_rs, dec_rt, dec_we_reg, dec_pc}),
            64'({1'b1, 6'h01, 5'd3, 5'd1, 5'd2, 1'b1, 16'd4}));

        // Load-use: LD r5 then ADD r6,r5,r1.
        step(0, 1, enc(6'h08, 5, 0, 0), 16'd5, 1, s);
        step(0, 1, enc(6'h01, 6, 5, 1), 16'd6, 1, s);
        chk("hazard_stall", 64'(s), 64'd1);
        chk("hazard_bubble", 64'(dec_valid), 64'd0);
        step(0, 1, enc(6'h01, 6, 5, 1), 16'd6, 1, s);
        chk("hazard_release", 64'(s), 64'd0);
        chk("hazard_issue", 64'({dec_valid, dec_rd, dec_pc}), 64'({1'b1, 5'd6, 16'd6}));

        // JMP 0x0037 at pc 8, wrong-path word at pc 9, target at 55.
        step(0, 1, enc_imm(6'h10, 16'h0037), 16'd8, 1, s);
        chk("jmp_pulse", 64'({jump_flag, jump_addr, dec_we_reg}), 64'({1'b1, 16'd55, 1'b0}));
        step(0, 1, enc(6'h02, 1, 2, 3), 16'd9, 1, s);
        chk("jmp_pulse_end", 64'(jump_flag), 64'd0);
        chk("flush_drop", 64'(dec_valid), 64'd0);
        step(0, 1, enc(6'h02, 1, 2, 3), 16'd55, 1, s);
        chk("jmp_target", 64'({dec_valid, dec_pc}), 64'({1'b1, 16'd55}));

        // Back-pressure for 3 cycles.
        step(0, 1, enc(6'h01, 7, 1, 2), 16'd60, 1, s);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, enc(6'h02, 4, 1, 2), 16'd61, 0, s);
            chk("bp_stall", 64'(s), 64'd1);
            chk("bp_hold", 64'({dec_valid, dec_pc, dec_rd}), 64'({1'b1, 16'd60, 5'd7}));
        end
        step(0, 1, enc(6'h02, 4, 1, 2), 16'd61, 1, s);
        chk("bp_issue", 64'({dec_valid, dec_pc}), 64'({1'b1, 16'd61}));

        // Illegal opcode, then HALT.
        step(0, 1, enc(6'h2A, 1, 1, 1), 16'd62, 1, s);
        chk("illegal_pulse", 64'({illegal_op, dec_valid, dec_opcode, dec_we_reg}),
            64'({1'b1, 1'b1, 6'h00, 1'b0}));
        step(0, 0, '0, 16'd63, 1, s);
        chk("illegal_end", 64'(illegal_op), 64'd0);
        step(0, 1, enc(6'h3F, 0, 0, 0), 16'd63, 1, s);
        chk("halt_set", 64'({halted, dec_valid, dec_opcode}), 64'({1'b1, 1'b1, 6'h3F}));
        for (int i = 0; i < 3; i++) begin
            step(0, 1, enc(6'h01, 1, 2, 3), 16'd64, 1, s);
            chk("halt_stall", 64'({s, halted}), 64'({1'b1, 1'b1}));
        end
        step(1, 0, '0, '0, 1, s);
        chk("halt_clear", 64'(halted), 64'd0);

        // Randomized stream; fetch holds its word while stalled.
        last_stall = 0; cur_iv = 0; cur_w = '0; cur_p = '0;
        for (int c = 0; c < 4000; c++) begin
            r = (m_halted && ($urandom_range(3) == 0)) || ($urandom_range(99) == 0);
            if (!(cur_iv && last_stall)) begin
                cur_iv = ($urandom_range(9) < 8);
                cur_w  = rand_instr();
                cur_p  = 16'($urandom);
            end
            ex = ($urandom_range(3) != 0);
            step(r, cur_iv, cur_w, cur_p, ex, last_stall);
            if (r) last_stall = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
